// File: rtl/instr_encoder_loader_if.sv
// Field-bundle input, instruction-memory write port and status of the instruction encoder/loader.
// The loader connects through the slave modport; whatever feeds it programs uses master.
interface instr_encoder_loader_if #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) ();
    logic              start_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic              in_last_i;
    logic [6:0]        op_code_i;
    logic [4:0]        rd_i;
    logic [4:0]        rs1_i;
    logic [4:0]        rs2_i;
    logic [2:0]        funct3_i;
    logic [6:0]        funct7_i;
    logic [31:0]       imm_i;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [ADDR_W:0]   count_o;
    logic              busy_o;
    logic              done_o;
    logic              full_o;
    logic              err_o;

    modport master (
        output start_i, in_valid_i, in_last_i, op_code_i, rd_i, rs1_i, rs2_i,
               funct3_i, funct7_i, imm_i,
        input  in_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, count_o,
               busy_o, done_o, full_o, err_o
    );

    modport slave (
        input  start_i, in_valid_i, in_last_i, op_code_i, rd_i, rs1_i, rs2_i,
               funct3_i, funct7_i, imm_i,
        output in_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, count_o,
               busy_o, done_o, full_o, err_o
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes RV32I field bundles into instruction words and streams them into
// instruction memory at sequential word addresses, starting from 0 on each start_i.
module instr_encoder_loader #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    instr_encoder_loader_if.slave  bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               full_q, full_d;
    logic               err_q, err_d;

    logic [31:0]        enc_c;
    logic               legal_c;
    logic               accept_c;
    logic [CNT_W-1:0]   cnt_inc_c;

    // Field packing per instruction format; anything unlisted (incl. JALR) is rejected.
    always_comb begin
        enc_c   = '0;
        legal_c = 1'b1;
        case (bus.op_code_i)
            OP_LOAD, OP_IMM:
                enc_c = {bus.imm_i[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, bus.op_code_i};
            OP_STORE:
                enc_c = {bus.imm_i[11:5], bus.rs2_i, bus.rs1_i, bus.funct3_i,
                         bus.imm_i[4:0], bus.op_code_i};
            OP_REG:
                enc_c = {bus.funct7_i, bus.rs2_i, bus.rs1_i, bus.funct3_i, bus.rd_i,
                         bus.op_code_i};
            OP_BRANCH:
                enc_c = {bus.imm_i[12], bus.imm_i[10:5], bus.rs2_i, bus.rs1_i, bus.funct3_i,
                         bus.imm_i[4:1], bus.imm_i[11], bus.op_code_i};
            OP_LUI, OP_AUIPC:
                enc_c = {bus.imm_i[31:12], bus.rd_i, bus.op_code_i};
            OP_JAL:
                enc_c = {bus.imm_i[20], bus.imm_i[10:1], bus.imm_i[11], bus.imm_i[19:12],
                         bus.rd_i, bus.op_code_i};
            default:
                legal_c = 1'b0;
        endcase
    end

    assign accept_c  = bus.in_valid_i && (state_q == LOAD);
    assign cnt_inc_c = cnt_q + CNT_W'(1);

    // Next state, write strobe and counters.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        full_d  = full_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start_i) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    cnt_d   = '0;
                    full_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (accept_c) begin
                    if (legal_c) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = enc_c;
                        addr_d  = addr_q + ADDR_W'(1);
                        cnt_d   = cnt_inc_c;
                        if (cnt_inc_c == CNT_W'(DEPTH)) begin
                            full_d  = 1'b1;
                            state_d = DONE;
                        end else if (bus.in_last_i) begin
                            state_d = DONE;
                        end
                    end else begin
                        err_d = 1'b1;
                        if (bus.in_last_i) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready_o  = (state_q == LOAD);
    assign bus.busy_o      = (state_q == LOAD);
    assign bus.done_o      = (state_q == DONE);
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = waddr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.count_o     = cnt_q;
    assign bus.full_o      = full_q;
    assign bus.err_o       = err_q;
endmodule
